// File: rtl/ssm_pkg.sv
// Shared SSM types, FP16 constants and flat-bus slice offsets.
// Used by the head scheduler and the other SSM datapath blocks.
package ssm_pkg;

  localparam int SSM_DW = 16;

  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_ONE  = 16'h3C00;
  localparam logic [15:0] FP16_TWO  = 16'h4000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } sched_state_e;

  function automatic int x_off(
    input int j,
    input int k,
    input int p_dim,
    input int dw
  );
    return dw * (j * p_dim + k);
  endfunction

  function automatic int h_off(
    input int j,
    input int p,
    input int n,
    input int p_dim,
    input int n_dim,
    input int dw
  );
    return dw * (j * p_dim * n_dim + p * n_dim + n);
  endfunction

endpackage

// File: rtl/ssm_head_slice_mux.sv
// Combinational select of one head's operands from flat buses.
// Feeds the scheduler's core operand registers.
module ssm_head_slice_mux
  import ssm_pkg::*;
#(
  parameter int H  = 4,
  parameter int P  = 4,
  parameter int N  = 4,
  parameter int DW = SSM_DW,
  parameter int HW = 2
) (
  input  logic [HW-1:0]       sel,
  input  logic [H*DW-1:0]     dt_flat,
  input  logic [H*DW-1:0]     dA_flat,
  input  logic [H*DW-1:0]     D_flat,
  input  logic [H*P*DW-1:0]   x_flat,
  input  logic [H*P*N*DW-1:0] h_flat,
  output logic [DW-1:0]       dt,
  output logic [DW-1:0]       dA,
  output logic [DW-1:0]       D,
  output logic [P*DW-1:0]     x,
  output logic [P*N*DW-1:0]   h_prev
);

  assign dt = dt_flat[int'(sel)*DW +: DW];
  assign dA = dA_flat[int'(sel)*DW +: DW];
  assign D  = D_flat[int'(sel)*DW +: DW];
  assign x  = x_flat[x_off(int'(sel), 0, P, DW) +: P*DW];
  assign h_prev =
    h_flat[h_off(int'(sel), 0, 0, P, N, DW) +: P*N*DW];

endmodule

// File: rtl/ssm_head_scheduler.sv
// Time-multiplexes one single-head SSM core over H heads.
// Snapshots the token operands, issues heads, collects y/h_next.
module ssm_head_scheduler
  import ssm_pkg::*;
#(
  parameter int H        = 4,
  parameter int P        = 4,
  parameter int N        = 4,
  parameter int DW       = SSM_DW,
  parameter int MAX_WAIT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [H*DW-1:0]       dt_flat,
  input  logic [H*DW-1:0]       dA_flat,
  input  logic [H*DW-1:0]       D_flat,
  input  logic [N*DW-1:0]       Bmat_flat,
  input  logic [N*DW-1:0]       C_flat,
  input  logic [H*P*DW-1:0]     x_flat,
  input  logic [H*P*N*DW-1:0]   h_prev_flat,
  output logic                  core_start,
  output logic [DW-1:0]         core_dt,
  output logic [DW-1:0]         core_dA,
  output logic [DW-1:0]         core_D,
  output logic [N*DW-1:0]       core_B,
  output logic [N*DW-1:0]       core_C,
  output logic [P*DW-1:0]       core_x,
  output logic [P*N*DW-1:0]     core_h_prev,
  input  logic [P*DW-1:0]       core_y,
  input  logic [P*N*DW-1:0]     core_h_next,
  input  logic                  core_done,
  output logic [H*P*DW-1:0]     y_flat,
  output logic [H*P*N*DW-1:0]   h_next_flat,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int HW = (H > 1) ? $clog2(H) : 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  sched_state_e st;
  logic [HW-1:0] head;
  logic [WW-1:0] wcnt;

  logic [H*DW-1:0]     s_dt, s_dA, s_D;
  logic [H*P*DW-1:0]   s_x;
  logic [H*P*N*DW-1:0] s_h;

  logic                idle, last, accept, advance;
  logic [HW-1:0]       m_sel;
  logic [H*DW-1:0]     m_dt, m_dA, m_D;
  logic [H*P*DW-1:0]   m_x;
  logic [H*P*N*DW-1:0] m_h;
  logic [DW-1:0]       mx_dt, mx_dA, mx_D;
  logic [P*DW-1:0]     mx_x;
  logic [P*N*DW-1:0]   mx_h;

  assign idle    = (st == ST_IDLE);
  assign last    = (head == HW'(H - 1));
  assign accept  = idle && start;
  assign advance = (st == ST_WAIT) && core_done && !last;

  // Head 0 loads straight from the live inputs on the accepting
  // edge so the operands are already valid in the first ISSUE cycle.
  assign m_sel = idle ? '0 : head + HW'(1);
  assign m_dt  = idle ? dt_flat : s_dt;
  assign m_dA  = idle ? dA_flat : s_dA;
  assign m_D   = idle ? D_flat : s_D;
  assign m_x   = idle ? x_flat : s_x;
  assign m_h   = idle ? h_prev_flat : s_h;

  ssm_head_slice_mux #(
    .H (H),
    .P (P),
    .N (N),
    .DW(DW),
    .HW(HW)
  ) u_mux (
    .sel    (m_sel),
    .dt_flat(m_dt),
    .dA_flat(m_dA),
    .D_flat (m_D),
    .x_flat (m_x),
    .h_flat (m_h),
    .dt     (mx_dt),
    .dA     (mx_dA),
    .D      (mx_D),
    .x      (mx_x),
    .h_prev (mx_h)
  );

  assign core_start = (st == ST_ISSUE);
  assign busy       = !idle;
  assign done       = (st == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= ST_IDLE;
      head        <= '0;
      wcnt        <= '0;
      err         <= 1'b0;
      s_dt        <= '0;
      s_dA        <= '0;
      s_D         <= '0;
      s_x         <= '0;
      s_h         <= '0;
      core_dt     <= '0;
      core_dA     <= '0;
      core_D      <= '0;
      core_B      <= '0;
      core_C      <= '0;
      core_x      <= '0;
      core_h_prev <= '0;
      y_flat      <= '0;
      h_next_flat <= '0;
    end else begin
      if (accept || advance) begin
        core_dt     <= mx_dt;
        core_dA     <= mx_dA;
        core_D      <= mx_D;
        core_x      <= mx_x;
        core_h_prev <= mx_h;
      end
      unique case (st)
        ST_IDLE: begin
          if (start) begin
            s_dt        <= dt_flat;
            s_dA        <= dA_flat;
            s_D         <= D_flat;
            s_x         <= x_flat;
            s_h         <= h_prev_flat;
            core_B      <= Bmat_flat;
            core_C      <= C_flat;
            y_flat      <= '0;
            h_next_flat <= '0;
            head        <= '0;
            err         <= 1'b0;
            st          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wcnt <= '0;
          st   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done) begin
            y_flat[x_off(int'(head), 0, P, DW) +: P*DW] <= core_y;
            h_next_flat[h_off(int'(head), 0, 0, P, N, DW) +: P*N*DW]
              <= core_h_next;
            if (last) begin
              st <= ST_DONE;
            end else begin
              head <= head + HW'(1);
              st   <= ST_ISSUE;
            end
          end else if (wcnt == WW'(MAX_WAIT - 1)) begin
            err <= 1'b1;
            st  <= ST_DONE;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        ST_DONE: st <= ST_IDLE;
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ssm_head_scheduler.sv
// Directed bench for ssm_head_scheduler with an echoing mock core.
// Mock core: latency 3, y = x slice, h_next = h_prev slice.
module tb_ssm_head_scheduler;
  import ssm_pkg::*;

  localparam int H  = 4;
  localparam int P  = 4;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MW = 8;
  localparam int YW = H*P*DW;
  localparam int HWD = H*P*N*DW;
  localparam int HS = P*N*DW;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [H*DW-1:0] dt_flat, dA_flat, D_flat;
  logic [N*DW-1:0] b_flat, c_flat;
  logic [YW-1:0]   x_flat;
  logic [HWD-1:0]  h_flat;

  logic            core_start;
  logic [DW-1:0]   core_dt, core_dA, core_D;
  logic [N*DW-1:0] core_B, core_C;
  logic [P*DW-1:0] core_x;
  logic [HS-1:0]   core_h_prev;
  logic [P*DW-1:0] core_y = '0;
  logic [HS-1:0]   core_h_next = '0;
  logic            core_done = 1'b0;
  logic [YW-1:0]   y_flat;
  logic [HWD-1:0]  h_next_flat;
  logic            busy, done, err;

  always #5 clk = ~clk;

  ssm_head_scheduler #(
    .H(H), .P(P), .N(N), .DW(DW), .MAX_WAIT(MW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dt_flat    (dt_flat),
    .dA_flat    (dA_flat),
    .D_flat     (D_flat),
    .Bmat_flat  (b_flat),
    .C_flat     (c_flat),
    .x_flat     (x_flat),
    .h_prev_flat(h_flat),
    .core_start (core_start),
    .core_dt    (core_dt),
    .core_dA    (core_dA),
    .core_D     (core_D),
    .core_B     (core_B),
    .core_C     (core_C),
    .core_x     (core_x),
    .core_h_prev(core_h_prev),
    .core_y     (core_y),
    .core_h_next(core_h_next),
    .core_done  (core_done),
    .y_flat     (y_flat),
    .h_next_flat(h_next_flat),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Mock core; mute_n silences one issue (absolute issue index).
  int ncs = 0;
  int mute_n = -1;
  logic pend = 1'b0;
  int cnt = 0;
  logic [P*DW-1:0] lx;
  logic [HS-1:0]   lh;
  logic [DW-1:0]   log_dt [64];
  logic [N*DW-1:0] log_b [64];

  always @(posedge clk) begin
    core_done <= 1'b0;
    if (core_start) begin
      if (ncs < 64) begin
        log_dt[ncs] <= core_dt;
        log_b[ncs]  <= core_B;
      end
      if (ncs != mute_n) begin
        pend <= 1'b1;
        cnt  <= 2;
        lx   <= core_x;
        lh   <= core_h_prev;
      end
      ncs <= ncs + 1;
    end else if (pend) begin
      if (cnt == 1) begin
        core_done   <= 1'b1;
        pend        <= 1'b0;
        core_y      <= lx;
        core_h_next <= lh;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at cycle 1 after the accepting edge.
  task automatic wait_done(input int inj_k, output int lat,
                           output int starts);
    lat = -1;
    starts = 0;
    for (int k = 1; k <= 100; k++) begin
      if (core_start) starts++;
      if (done) begin
        lat = k;
        break;
      end
      if (k == inj_k) begin
        start = 1'b1;
        x_flat = '1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic run(input int inj_k, output int lat,
                     output int starts);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(inj_k, lat, starts);
  endtask

  logic [YW-1:0]  x_orig, exp_y;
  logic [HWD-1:0] exp_h;
  logic [N*DW-1:0] exp_b;
  int lat, starts, base;
  logic saw_done, saw_cd;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    for (int j = 0; j < H; j++) begin
      dt_flat[j*DW +: DW] = 16'h3C00 + 16'(j);
      dA_flat[j*DW +: DW] = 16'h3C00 + 16'(j);
      D_flat[j*DW +: DW]  = 16'h3C00 + 16'(j);
      for (int k = 0; k < P; k++)
        x_flat[(j*P+k)*DW +: DW] = 16'h0100 * 16'(j) + 16'(k);
    end
    for (int i = 0; i < H*P*N; i++)
      h_flat[i*DW +: DW] = 16'h2000 + 16'(i);
    for (int n = 0; n < N; n++) begin
      b_flat[n*DW +: DW] = FP16_TWO;
      c_flat[n*DW +: DW] = FP16_ONE;
    end
    exp_b = b_flat;
    x_orig = x_flat;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    chk("rst_core_start", 256'(core_start), 256'(0));
    chk("rst_core_dt", 256'(core_dt), 256'(0));
    chk("rst_core_x", 256'(core_x), 256'(0));
    chk("rst_y", 256'(y_flat), 256'(0));
    chk("rst_h", h_next_flat[HS-1:0], 256'(0));

    // Nominal echo and operand routing
    base = ncs;
    run(-1, lat, starts);
    chk("nom_latency", 256'(lat), 256'(17));
    chk("nom_starts", 256'(starts), 256'(4));
    chk("nom_err", 256'(err), 256'(0));
    chk("nom_y", 256'(y_flat), 256'(x_orig));
    for (int j = 0; j < H; j++) begin
      chk($sformatf("nom_h%0d", j), h_next_flat[j*HS +: HS],
          h_flat[j*HS +: HS]);
      chk($sformatf("route_dt%0d", j), 256'(log_dt[base+j]),
          256'(16'h3C00 + 16'(j)));
      chk($sformatf("route_b%0d", j), 256'(log_b[base+j]),
          256'(exp_b));
    end
    tick();
    chk("nom_idle", 256'(busy), 256'(0));

    // Snapshot: corrupt x and pulse start in head 1 WAIT
    run(6, lat, starts);
    chk("snap_latency", 256'(lat), 256'(17));
    chk("snap_starts", 256'(starts), 256'(4));
    chk("snap_y", 256'(y_flat), 256'(x_orig));
    x_flat = x_orig;
    tick();

    // Watchdog: head 2 never answered
    mute_n = ncs + 2;
    run(-1, lat, starts);
    chk("wd_latency", 256'(lat), 256'(18));
    chk("wd_starts", 256'(starts), 256'(3));
    chk("wd_err", 256'(err), 256'(1));
    exp_y = x_orig;
    exp_y[YW-1:2*P*DW] = '0;
    exp_h = h_flat;
    exp_h[HWD-1:2*HS] = '0;
    chk("wd_y", 256'(y_flat), 256'(exp_y));
    for (int j = 0; j < H; j++)
      chk($sformatf("wd_h%0d", j), h_next_flat[j*HS +: HS],
          exp_h[j*HS +: HS]);
    mute_n = -1;

    // Back-to-back: start in DONE ignored, next cycle accepted
    start = 1'b1;
    tick();
    chk("b2b_ignored", 256'(busy), 256'(0));
    chk("wd_err_hold", 256'(err), 256'(1));
    tick();
    start = 1'b0;
    chk("b2b_accept", 256'(busy), 256'(1));
    chk("err_cleared", 256'(err), 256'(0));
    wait_done(-1, lat, starts);
    chk("b2b_latency", 256'(lat), 256'(17));
    chk("b2b_y", 256'(y_flat), 256'(x_orig));
    tick();

    // Reset during head 1 WAIT, late core_done must be ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 6; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", 256'(busy), 256'(0));
    chk("mrst_core_dt", 256'(core_dt), 256'(0));
    chk("mrst_y0", 256'(y_flat), 256'(0));
    saw_done = 1'b0;
    saw_cd = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done) saw_done = 1'b1;
      if (core_done) saw_cd = 1'b1;
    end
    chk("mrst_late_cd_seen", 256'(saw_cd), 256'(1));
    chk("mrst_no_done", 256'(saw_done), 256'(0));
    chk("mrst_busy_after", 256'(busy), 256'(0));
    chk("mrst_core_start", 256'(core_start), 256'(0));
    chk("mrst_err", 256'(err), 256'(0));
    chk("mrst_y", 256'(y_flat), 256'(0));
    for (int j = 0; j < H; j++)
      chk($sformatf("mrst_h%0d", j), h_next_flat[j*HS +: HS],
          256'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
